// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: command/burst transaction controller behind an SPI slave byte port.
// Owns a NUM_REGS x 8 register bank with an auto-incrementing burst address.
module spi_reg_ctrl #(
  parameter int         NUM_REGS = 16,
  parameter logic [7:0] DEV_ID   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ss,
  input  logic                  rx_data_available,
  input  logic [0:7]            rx_data,
  input  logic                  tx_empty,
  output logic [0:7]            tx_data,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_stb,
  output logic [6:0]            wr_addr,
  output logic [7:0]            wr_data,
  output logic                  frame_done,
  output logic                  addr_err
);

  localparam int         AW   = $clog2(NUM_REGS);
  localparam logic [7:0] NR8  = 8'(NUM_REGS);
  localparam logic [6:0] LAST = 7'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, RD, WR, DROP
  } state_t;

  state_t state, state_nxt;

  logic       ss_q, rxa_q, txe_q;
  logic       ss_fall, ss_rise;
  logic       byte_evt, load_evt;
  logic [6:0] addr, addr_nxt;
  logic       load_pend, pend_nxt;
  logic [7:0] regs [NUM_REGS];
  logic [6:0] cmd_addr;
  logic       cmd_ok;
  logic       do_wr, do_tx;
  logic [7:0] tx_nxt;
  logic       err_set, err_clr;
  logic       fdone;

  function automatic logic [6:0] next_addr(input logic [6:0] a);
    return (a == LAST) ? 7'd0 : a + 7'd1;
  endfunction

  assign ss_fall  = ss_q & ~ss;
  assign ss_rise  = ~ss_q & ss;
  assign byte_evt = rx_data_available & ~rxa_q;
  assign load_evt = tx_empty & ~txe_q;

  assign cmd_addr = rx_data[1:7];
  assign cmd_ok   = {1'b0, cmd_addr} < NR8;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[8*i +: 8] = regs[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    pend_nxt  = load_pend;
    do_wr     = 1'b0;
    do_tx     = 1'b0;
    tx_nxt    = 8'h00;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    fdone     = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt = CMD;
          do_tx     = 1'b1;
          tx_nxt    = DEV_ID;
          pend_nxt  = 1'b0;
        end
      end
      CMD: begin
        // a load request seen before/with decode is served once decoded
        if (load_evt) pend_nxt = 1'b1;
        if (byte_evt) begin
          addr_nxt = cmd_addr;
          if (cmd_ok) begin
            state_nxt = rx_data[0] ? RD : WR;
            err_clr   = 1'b1;
          end else begin
            state_nxt = DROP;
            err_set   = 1'b1;
          end
        end
      end
      RD: begin
        if (load_evt || load_pend) begin
          do_tx    = 1'b1;
          tx_nxt   = regs[addr[AW-1:0]];
          addr_nxt = next_addr(addr);
          pend_nxt = 1'b0;
        end
      end
      WR: begin
        if (byte_evt) begin
          do_wr    = 1'b1;
          addr_nxt = next_addr(addr);
        end
        if (load_evt || load_pend) begin
          do_tx    = 1'b1;
          tx_nxt   = 8'h00;
          pend_nxt = 1'b0;
        end
      end
      DROP: begin
        if (load_evt || load_pend) begin
          do_tx    = 1'b1;
          tx_nxt   = 8'hFF;
          pend_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE) begin
      if (ss_fall) begin
        state_nxt = CMD;
        do_tx     = 1'b1;
        tx_nxt    = DEV_ID;
        pend_nxt  = 1'b0;
      end else if (ss_rise) begin
        state_nxt = IDLE;
        fdone     = 1'b1;
        pend_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q       <= 1'b0;
      rxa_q      <= 1'b0;
      txe_q      <= 1'b0;
      addr       <= '0;
      load_pend  <= 1'b0;
      tx_data    <= '0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      addr_err   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      ss_q       <= ss;
      rxa_q      <= rx_data_available;
      txe_q      <= tx_empty;
      addr       <= addr_nxt;
      load_pend  <= pend_nxt;
      wr_stb     <= do_wr;
      frame_done <= fdone;
      if (do_tx) tx_data <= tx_nxt;
      if (do_wr) begin
        regs[addr[AW-1:0]] <= rx_data;
        wr_addr            <= addr;
        wr_data            <= rx_data;
      end
      if (err_set)      addr_err <= 1'b1;
      else if (err_clr) addr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed and random frames against a register-bank model.
// Drives the slave byte interface at transaction level and checks MISO/writes/flags.
module tb_spi_reg_ctrl;

  localparam int NR = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ss = 1'b1;
  logic            rxa = 1'b0;
  logic            txe = 1'b0;
  logic [0:7]      rx_data = '0;
  logic [0:7]      tx_data;
  logic [NR*8-1:0] regs_flat;
  logic            wr_stb;
  logic [6:0]      wr_addr;
  logic [7:0]      wr_data;
  logic            frame_done;
  logic            addr_err;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] model [NR];
  logic [7:0] mosi [16];
  logic [7:0] miso [16];
  int wlog_a[$];
  int wlog_d[$];
  int fd_cnt = 0;

  always #5 clk = ~clk;

  spi_reg_ctrl #(.NUM_REGS(NR), .DEV_ID(8'hA5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ss(ss),
    .rx_data_available(rxa),
    .rx_data(rx_data),
    .tx_empty(txe),
    .tx_data(tx_data),
    .regs_flat(regs_flat),
    .wr_stb(wr_stb),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_done(frame_done),
    .addr_err(addr_err)
  );

  always @(negedge clk) begin
    if (wr_stb) begin
      wlog_a.push_back(int'(wr_addr));
      wlog_d.push_back(int'(wr_data));
    end
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[8*i +: 8] = model[i];
    return f;
  endfunction

  task automatic begin_frame();
    @(negedge clk);
    ss = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic byte_xfer(input logic [7:0] b, output logic [7:0] m);
    m = tx_data;
    repeat (8) @(negedge clk);
    rx_data = b;
    rxa = 1'b1;
    txe = 1'b1;
    repeat (4) @(negedge clk);
    rxa = 1'b0;
    txe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_frame();
    ss = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // full frame: command plus mosi[1..nd], checked against the model
  task automatic xfer(input logic [7:0] cmd, input int nd);
    logic [7:0] exp_m[$];
    int ea[$];
    int ed[$];
    int a, w0, f0;
    bit rd, ok;
    rd = cmd[7];
    a  = int'(cmd[6:0]);
    ok = a < NR;
    exp_m.push_back(8'hA5);
    for (int i = 1; i <= nd; i++) begin
      if (!ok) exp_m.push_back(8'hFF);
      else if (rd) begin
        exp_m.push_back(model[a]);
        a = (a + 1) % NR;
      end else begin
        exp_m.push_back(8'h00);
        model[a] = mosi[i];
        ea.push_back(a);
        ed.push_back(int'(mosi[i]));
        a = (a + 1) % NR;
      end
    end
    w0 = wlog_a.size();
    f0 = fd_cnt;
    mosi[0] = cmd;
    begin_frame();
    for (int i = 0; i <= nd; i++) byte_xfer(mosi[i], miso[i]);
    end_frame();
    for (int i = 0; i <= nd; i++)
      check($sformatf("miso[%0d] cmd=%h", i, cmd), miso[i], exp_m[i]);
    check($sformatf("wr count cmd=%h", cmd), wlog_a.size() - w0, ea.size());
    for (int i = 0; i < ea.size() && w0 + i < wlog_a.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), wlog_a[w0+i], ea[i]);
      check($sformatf("wr_data[%0d]", i), wlog_d[w0+i], ed[i]);
    end
    check($sformatf("regs cmd=%h", cmd), regs_flat, model_flat());
    check($sformatf("addr_err cmd=%h", cmd), addr_err, !ok);
    check($sformatf("frame_done cmd=%h", cmd), fd_cnt - f0, 1);
  endtask

  initial begin
    logic [7:0] m;
    int w0, f0, nd;
    logic [7:0] cmd;
    for (int i = 0; i < NR; i++) model[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst regs", regs_flat, '0);
    check("rst tx_data", tx_data, 8'h00);
    check("rst wr_stb", wr_stb, 1'b0);
    check("rst wr_addr", wr_addr, 7'd0);
    check("rst wr_data", wr_data, 8'h00);
    check("rst frame_done", frame_done, 1'b0);
    check("rst addr_err", addr_err, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    mosi[1] = 8'h11; mosi[2] = 8'h22; mosi[3] = 8'h33;
    xfer(8'h03, 3);

    for (int i = 1; i <= 3; i++) mosi[i] = 8'($urandom);
    xfer(8'h83, 3);

    mosi[1] = 8'hAA; mosi[2] = 8'hBB; mosi[3] = 8'hCC;
    xfer(8'h0F, 3);

    mosi[1] = 8'h55;
    xfer(8'h40, 1);
    mosi[1] = 8'($urandom);
    xfer(8'h85, 1);

    // frame cut short in the middle of the second data byte
    w0 = wlog_a.size();
    f0 = fd_cnt;
    begin_frame();
    byte_xfer(8'h06, m);
    byte_xfer(8'h77, m);
    model[6] = 8'h77;
    repeat (4) @(negedge clk);
    end_frame();
    check("cut wr count", wlog_a.size() - w0, 1);
    if (wlog_a.size() > w0) begin
      check("cut wr_addr", wlog_a[w0], 6);
      check("cut wr_data", wlog_d[w0], 8'h77);
    end
    check("cut regs", regs_flat, model_flat());
    check("cut frame_done", fd_cnt - f0, 1);
    mosi[1] = 8'h00; mosi[2] = 8'h00;
    xfer(8'h86, 2);

    // reset in the middle of a read burst, ss held low
    begin_frame();
    byte_xfer(8'h81, m);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst regs", regs_flat, '0);
    check("midrst tx_data", tx_data, 8'h00);
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    rst_n = 1'b1;
    w0 = wlog_a.size();
    f0 = fd_cnt;
    repeat (3) @(negedge clk);
    byte_xfer(8'h01, m);
    check("postrst miso0", m, 8'h00);
    byte_xfer(8'h5A, m);
    check("postrst miso1", m, 8'h00);
    end_frame();
    check("postrst wr count", wlog_a.size() - w0, 0);
    check("postrst regs", regs_flat, '0);
    check("postrst frame_done", fd_cnt - f0, 0);
    mosi[1] = 8'($urandom);
    xfer(8'h80, 1);

    for (int k = 0; k < 14; k++) begin
      cmd = {1'($urandom), 7'($urandom_range(0, NR + 3))};
      nd = $urandom_range(1, 5);
      for (int i = 1; i <= nd; i++) mosi[i] = 8'($urandom);
      xfer(cmd, nd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
